// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter
// Purpose  : Round-robin bus arbiter with registered one-hot grant, hold-time
//            watchdog and per-requester lockout after a watchdog revocation.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                 CK,
    input  logic                 nCL,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 BUSY,
    output logic                 TOUT,
    output logic [N-1:0]         LOCK
);

    localparam int c_ownerWidth = $clog2(N);
    localparam int c_sumWidth   = c_ownerWidth + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } stateT;

    stateT                   r_state,  w_stateNxt;
    logic [N-1:0]            r_gnt,    w_gntNxt;
    logic [c_ownerWidth-1:0] r_owner,  w_ownerNxt;
    logic [c_ownerWidth-1:0] r_ptr,    w_ptrNxt;
    logic [TW-1:0]           r_timer,  w_timerNxt;
    logic                    r_busy,   w_busyNxt;
    logic                    r_tout,   w_toutNxt;
    logic [N-1:0]            r_lock,   w_lockNxt;

    logic [N-1:0]            w_elig;
    logic [2*N-1:0]          w_eligDbl;
    logic [N-1:0]            w_rot;
    logic                    w_found;
    logic [c_sumWidth-1:0]   w_pickSum;
    logic [c_ownerWidth-1:0] w_pick;
    logic [c_ownerWidth-1:0] w_ownerInc;
    logic                    w_ownerReq;
    logic                    w_timeout;

    assign w_elig    = REQ & ~r_lock;
    // Rotate eligibility so bit 0 corresponds to the requester at PTR.
    assign w_eligDbl = {w_elig, w_elig};
    assign w_rot     = w_eligDbl[{1'b0, r_ptr} +: N];

    always_comb begin
        w_found   = 1'b0;
        w_pickSum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found   = 1'b1;
                w_pickSum = {1'b0, r_ptr} + c_sumWidth'(k);
            end
        end
        if (w_pickSum >= c_sumWidth'(N)) begin
            w_pickSum = w_pickSum - c_sumWidth'(N);
        end
        w_pick = w_pickSum[c_ownerWidth-1:0];
    end

    assign w_ownerInc = (r_owner == c_ownerWidth'(N - 1)) ? '0 : r_owner + 1'b1;
    assign w_ownerReq = REQ[r_owner];
    // Release is checked first, so a timeout only fires while REQ is still high.
    assign w_timeout  = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        w_stateNxt = r_state;
        w_gntNxt   = r_gnt;
        w_ownerNxt = r_owner;
        w_ptrNxt   = r_ptr;
        w_timerNxt = r_timer;
        w_toutNxt  = 1'b0;
        w_lockNxt  = r_lock & REQ;
        case (r_state)
            S_IDLE: begin
                w_gntNxt = '0;
                if (w_found) begin
                    w_gntNxt   = N'(1) << w_pick;
                    w_ownerNxt = w_pick;
                    w_timerNxt = '0;
                    w_stateNxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_ownerReq) begin
                    w_gntNxt   = '0;
                    w_ptrNxt   = w_ownerInc;
                    w_stateNxt = S_TURN;
                end else if (w_timeout) begin
                    w_gntNxt   = '0;
                    w_toutNxt  = 1'b1;
                    w_lockNxt  = w_lockNxt | (N'(1) << r_owner);
                    w_ptrNxt   = w_ownerInc;
                    w_stateNxt = S_TURN;
                end else if (r_timer != {TW{1'b1}}) begin
                    w_timerNxt = r_timer + 1'b1;
                end
            end
            S_TURN: begin
                w_gntNxt   = '0;
                w_stateNxt = S_IDLE;
            end
            default: begin
                w_gntNxt   = '0;
                w_stateNxt = S_IDLE;
            end
        endcase
        w_busyNxt = |w_gntNxt;
    end

    always_ff @(posedge CK or negedge nCL) begin
        if (!nCL) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b0;
            r_lock  <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_gnt   <= w_gntNxt;
            r_owner <= w_ownerNxt;
            r_ptr   <= w_ptrNxt;
            r_timer <= w_timerNxt;
            r_busy  <= w_busyNxt;
            r_tout  <= w_toutNxt;
            r_lock  <= w_lockNxt;
        end
    end

    assign GNT   = r_gnt;
    assign OWNER = r_owner;
    assign BUSY  = r_busy;
    assign TOUT  = r_tout;
    assign LOCK  = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_arbiter
// Purpose  : Directed self-checking bench for rr_bus_arbiter (three builds:
//            default watchdog, TIMEOUT=5 and watchdog disabled).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter;

    logic       CK;
    logic       nCL;
    logic [3:0] reqA, reqW, reqZ;
    logic [3:0] gntA, gntW, gntZ;
    logic [1:0] ownA, ownW, ownZ;
    logic       busyA, busyW, busyZ;
    logic       toutA, toutW, toutZ;
    logic [3:0] lockA, lockW, lockZ;

    int nChecks = 0;
    int nFails  = 0;

    rr_bus_arbiter #(.N(4), .TIMEOUT(255), .TW(8)) dutA (
        .CK(CK), .nCL(nCL), .REQ(reqA), .GNT(gntA), .OWNER(ownA),
        .BUSY(busyA), .TOUT(toutA), .LOCK(lockA)
    );
    rr_bus_arbiter #(.N(4), .TIMEOUT(5), .TW(8)) dutW (
        .CK(CK), .nCL(nCL), .REQ(reqW), .GNT(gntW), .OWNER(ownW),
        .BUSY(busyW), .TOUT(toutW), .LOCK(lockW)
    );
    rr_bus_arbiter #(.N(4), .TIMEOUT(0), .TW(8)) dutZ (
        .CK(CK), .nCL(nCL), .REQ(reqZ), .GNT(gntZ), .OWNER(ownZ),
        .BUSY(busyZ), .TOUT(toutZ), .LOCK(lockZ)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
    } vecT;

    vecT vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic doReset();
        nCL = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        nCL = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int badGnt;
        int badTout;

        nCL  = 1'b0;
        reqA = 4'b0000;
        reqW = 4'b0000;
        reqZ = 4'b0000;

        // Fairness table: REQ applied before the edge, expected state after it.
        vecs[0]  = {4'b1111, 4'b0001, 2'd0};
        vecs[1]  = {4'b1111, 4'b0001, 2'd0};
        vecs[2]  = {4'b1111, 4'b0001, 2'd0};
        vecs[3]  = {4'b1110, 4'b0000, 2'd0};
        vecs[4]  = {4'b1111, 4'b0000, 2'd0};
        vecs[5]  = {4'b1111, 4'b0010, 2'd1};
        vecs[6]  = {4'b1111, 4'b0010, 2'd1};
        vecs[7]  = {4'b1111, 4'b0010, 2'd1};
        vecs[8]  = {4'b1101, 4'b0000, 2'd1};
        vecs[9]  = {4'b1111, 4'b0000, 2'd1};
        vecs[10] = {4'b1111, 4'b0100, 2'd2};
        vecs[11] = {4'b1111, 4'b0100, 2'd2};
        vecs[12] = {4'b1111, 4'b0100, 2'd2};
        vecs[13] = {4'b1011, 4'b0000, 2'd2};
        vecs[14] = {4'b1111, 4'b0000, 2'd2};
        vecs[15] = {4'b1111, 4'b1000, 2'd3};
        vecs[16] = {4'b1111, 4'b1000, 2'd3};
        vecs[17] = {4'b1111, 4'b1000, 2'd3};
        vecs[18] = {4'b0111, 4'b0000, 2'd3};
        vecs[19] = {4'b1111, 4'b0000, 2'd3};
        vecs[20] = {4'b1111, 4'b0001, 2'd0};

        // Reset state, then first grant one edge after release
        reqA = 4'b0110;
        repeat (2) @(posedge CK);
        #1;
        check("reset_gnt",   32'(gntA),  32'h0);
        check("reset_busy",  32'(busyA), 32'h0);
        check("reset_owner", 32'(ownA),  32'h0);
        check("reset_tout",  32'(toutW), 32'h0);
        check("reset_lock",  32'(lockW), 32'h0);
        nCL = 1'b1;
        step();
        check("first_gnt",   32'(gntA),  32'h2);
        check("first_owner", 32'(ownA),  32'h1);
        check("first_busy",  32'(busyA), 32'h1);

        // Round-robin fairness with two dead cycles between grants
        reqA = 4'b1111;
        doReset();
        for (int i = 0; i < 21; i++) begin
            reqA = vecs[i].req;
            step();
            check($sformatf("rr_gnt[%0d]", i),   32'(gntA),  32'(vecs[i].gnt));
            check($sformatf("rr_owner[%0d]", i), 32'(ownA),  32'(vecs[i].owner));
            check($sformatf("rr_busy[%0d]", i),  32'(busyA), 32'(|vecs[i].gnt));
        end
        check("rr_tout", 32'(toutA), 32'h0);

        // Watchdog at TIMEOUT=5 with lockout
        reqA = 4'b0000;
        doReset();
        reqW = 4'b1100;
        step();
        check("wd_gnt_first", 32'(gntW), 32'h4);
        check("wd_owner",     32'(ownW), 32'h2);
        for (int i = 2; i <= 5; i++) begin
            step();
            check($sformatf("wd_gnt_hold[%0d]", i), 32'(gntW),  32'h4);
            check($sformatf("wd_tout_low[%0d]", i), 32'(toutW), 32'h0);
        end
        step();
        check("wd_revoke_gnt", 32'(gntW),  32'h0);
        check("wd_tout_pulse", 32'(toutW), 32'h1);
        check("wd_lock_set",   32'(lockW), 32'h4);
        step();
        check("wd_tout_once",  32'(toutW), 32'h0);
        check("wd_dead_gnt",   32'(gntW),  32'h0);
        step();
        check("wd_next_gnt",   32'(gntW),  32'h8);
        check("wd_next_owner", 32'(ownW),  32'h3);
        step();
        reqW = 4'b0100;
        step();
        check("wd_rel3_gnt", 32'(gntW), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("wd_locked_gnt[%0d]", i), 32'(gntW), 32'h0);
        end
        check("wd_lock_held", 32'(lockW), 32'h4);
        reqW = 4'b0000;
        step();
        check("wd_lock_clear", 32'(lockW), 32'h0);
        reqW = 4'b0100;
        step();
        check("wd_regrant", 32'(gntW), 32'h4);
        repeat (4) step();
        step();
        check("wd_tout_again", 32'(toutW), 32'h1);
        check("wd_lock_again", 32'(lockW), 32'h4);

        // Wrap-around: PTR=3 after owner 2 releases, 0 beats 1
        reqA = 4'b0100;
        step();
        check("wrap_gnt2", 32'(gntA), 32'h4);
        reqA = 4'b0011;
        step();
        check("wrap_rel", 32'(gntA), 32'h0);
        step();
        check("wrap_dead", 32'(gntA), 32'h0);
        step();
        check("wrap_gnt0",   32'(gntA), 32'h1);
        check("wrap_owner0", 32'(ownA), 32'h0);

        // Asynchronous reset between edges during a grant
        #3;
        nCL = 1'b0;
        #1;
        check("async_gnt",  32'(gntA),  32'h0);
        check("async_busy", 32'(busyA), 32'h0);
        check("async_lock", 32'(lockW), 32'h0);
        reqA = 4'b1000;
        reqW = 4'b0000;
        @(posedge CK);
        #2;
        nCL = 1'b1;
        step();
        check("async_regrant", 32'(gntA),  32'h8);
        check("async_owner",   32'(ownA),  32'h3);
        check("async_busy_hi", 32'(busyA), 32'h1);

        // Watchdog disabled: grant held 1000 cycles
        reqA = 4'b0000;
        doReset();
        reqZ = 4'b0001;
        step();
        check("nowd_gnt", 32'(gntZ), 32'h1);
        badGnt  = 0;
        badTout = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (gntZ !== 4'b0001) badGnt++;
            if (toutZ !== 1'b0)   badTout++;
        end
        check("nowd_gnt_drops",  32'(badGnt),  32'h0);
        check("nowd_tout_count", 32'(badTout), 32'h0);
        check("nowd_lock",       32'(lockZ),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
